// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and constants for the register file slice
package rf_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;
  localparam int DEF_NRD = 2;
  localparam int NREG = 2**DEF_AW;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_sb_if.sv
// rf_sb_if: decode/issue and write-back bus of the register file
interface rf_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NRD = 2
);
  logic WrEn;
  logic [AW-1:0] Rw;
  logic [DW-1:0] busW;
  logic [NRD*AW-1:0] Ra;
  logic [NRD*DW-1:0] busA;
  logic [NRD-1:0] Rdy;
  logic IssEn;
  logic [AW-1:0] Rd_iss;
  logic IssOk;
  logic [AW:0] PendCnt;
  modport master (
    output WrEn, Rw, busW, Ra, IssEn, Rd_iss,
    input busA, Rdy, IssOk, PendCnt
  );
  modport slave (
    input WrEn, Rw, busW, Ra, IssEn, Rd_iss,
    output busA, Rdy, IssOk, PendCnt
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits, pending count and WAW check
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int NRD = DEF_NRD
) (
  input  logic Clk,
  input  logic Rst,
  input  logic IssEn,
  input  logic [AW-1:0] Rd_iss,
  input  logic WrEn,
  input  logic [AW-1:0] Rw,
  input  logic [NRD*AW-1:0] Ra,
  output logic [NRD-1:0] pend_rd,
  output logic IssOk,
  output logic [AW:0] PendCnt
);
  localparam int N = 2**AW;
  logic [N-1:0] pend, pend_nx;
  logic set, clr, inc, dec;
  always_comb begin
    set = IssEn && Rd_iss != AW'(ZERO_REG);
    clr = WrEn && Rw != AW'(ZERO_REG);
    inc = set && !pend[Rd_iss];
    dec = clr && pend[Rw] && !(set && Rd_iss == Rw);
    pend_nx = pend;
    if (clr) pend_nx[Rw] = 1'b0;
    if (set) pend_nx[Rd_iss] = 1'b1;
    IssOk = Rd_iss == AW'(ZERO_REG) || !pend[Rd_iss] || (WrEn && Rw == Rd_iss);
    pend_rd = '0;
    for (int i = 0; i < NRD; i++) pend_rd[i] = pend[Ra[i*AW +: AW]];
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend <= '0;
      PendCnt <= '0;
    end else begin
      pend <= pend_nx;
      PendCnt <= PendCnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end
endmodule

// File: rtl/rf_sb.sv
// rf_sb: register file with zero register, write bypass and pending-write scoreboard
module rf_sb
  import rf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NRD = DEF_NRD
) (
  input logic Clk,
  input logic Rst,
  rf_sb_if.slave bus
);
  localparam int N = 2**AW;
  logic [DW-1:0] r [N];
  logic [NRD-1:0] pend_rd;
  logic [AW-1:0] a;
  rf_scoreboard #(.AW(AW), .NRD(NRD)) sb (
    .Clk(Clk),
    .Rst(Rst),
    .IssEn(bus.IssEn),
    .Rd_iss(bus.Rd_iss),
    .WrEn(bus.WrEn),
    .Rw(bus.Rw),
    .Ra(bus.Ra),
    .pend_rd(pend_rd),
    .IssOk(bus.IssOk),
    .PendCnt(bus.PendCnt)
  );
  always_ff @(posedge Clk) begin
    if (Rst) for (int k = 0; k < N; k++) r[k] <= '0;
    else if (bus.WrEn && bus.Rw != AW'(ZERO_REG)) r[bus.Rw] <= bus.busW;
  end
  always_comb begin
    bus.busA = '0;
    bus.Rdy = '0;
    a = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.Ra[i*AW +: AW];
      bus.busA[i*DW +: DW] = a == AW'(ZERO_REG) ? '0 : (bus.WrEn && bus.Rw == a) ? bus.busW : r[a];
      bus.Rdy[i] = a == AW'(ZERO_REG) || !pend_rd[i] || (bus.WrEn && bus.Rw == a);
    end
  end
endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: scoreboard-driven checks of read, bypass, hazard tracking and reset
module tb_rf_sb;
  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0] rdy;
    logic ok;
    logic [5:0] cnt;
  } snap_t;
  logic Clk = 0, Rst = 0;
  snap_t exp_q[$];
  snap_t e, got;
  int tests = 0, fails = 0;
  rf_sb_if #(.DW(32), .AW(5), .NRD(2)) bus ();
  rf_sb #(.DW(32), .AW(5), .NRD(2)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  function automatic snap_t mk(logic [31:0] a0, logic [31:0] a1, logic [1:0] rdy, logic ok, logic [5:0] cnt);
    return '{a0, a1, rdy, ok, cnt};
  endfunction
  function automatic snap_t cur();
    return '{bus.busA[31:0], bus.busA[63:32], bus.Rdy, bus.IssOk, bus.PendCnt};
  endfunction
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic idle();
    bus.WrEn = 0; bus.IssEn = 0;
  endtask
  task automatic test_reset();
    idle(); bus.Rw = 0; bus.busW = 0; bus.Rd_iss = 0; bus.Ra = 0;
    Rst = 1;
    tick();
    Rst = 0; bus.Ra = {5'd11, 5'd10};
    exp_q.push_back(mk(0, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL reset_read got=%h exp=%h", got, e); end
  endtask
  task automatic test_write_bypass();
    bus.WrEn = 1; bus.Rw = 10; bus.busW = 32'h7;
    exp_q.push_back(mk(7, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL bypass_same got=%h exp=%h", got, e); end
    tick();
    idle();
    exp_q.push_back(mk(7, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL write_stored got=%h exp=%h", got, e); end
    tick();
    bus.WrEn = 1; bus.Rw = 0; bus.busW = 32'hFFFF_FFFF; bus.Ra = {5'd11, 5'd0};
    exp_q.push_back(mk(0, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL r0_nobypass got=%h exp=%h", got, e); end
    tick();
    idle();
    exp_q.push_back(mk(0, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL r0_nowrite got=%h exp=%h", got, e); end
  endtask
  task automatic test_raw();
    tick();
    bus.Ra = {5'd11, 5'd10}; bus.IssEn = 1; bus.Rd_iss = 11;
    exp_q.push_back(mk(7, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL raw_issue got=%h exp=%h", got, e); end
    tick();
    idle();
    exp_q.push_back(mk(7, 0, 2'b01, 0, 1));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL raw_pending got=%h exp=%h", got, e); end
    tick();
    bus.WrEn = 1; bus.Rw = 11; bus.busW = 15;
    exp_q.push_back(mk(7, 15, 2'b11, 1, 1));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL raw_wb_bypass got=%h exp=%h", got, e); end
    tick();
    idle();
    exp_q.push_back(mk(7, 15, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL raw_retired got=%h exp=%h", got, e); end
  endtask
  task automatic test_waw();
    tick();
    bus.Ra = {5'd5, 5'd10}; bus.IssEn = 1; bus.Rd_iss = 5;
    tick();
    idle();
    exp_q.push_back(mk(7, 0, 2'b01, 0, 1));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL waw_blocked got=%h exp=%h", got, e); end
    tick();
    bus.IssEn = 1; bus.WrEn = 1; bus.Rw = 5; bus.busW = 9;
    exp_q.push_back(mk(7, 9, 2'b11, 1, 1));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL setclr_same got=%h exp=%h", got, e); end
    tick();
    idle();
    exp_q.push_back(mk(7, 9, 2'b01, 0, 1));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL setclr_set_wins got=%h exp=%h", got, e); end
    tick();
    bus.WrEn = 1;
    tick();
    idle();
    exp_q.push_back(mk(7, 9, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL waw_retired got=%h exp=%h", got, e); end
  endtask
  task automatic test_fill();
    for (int k = 1; k < 32; k++) begin
      tick();
      bus.IssEn = 1; bus.Rd_iss = 5'(k);
    end
    tick();
    idle();
    bus.Ra = {5'd31, 5'd1};
    exp_q.push_back(mk(0, 0, 2'b00, 0, 31));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL fill_full got=%h exp=%h", got, e); end
    for (int k = 1; k < 32; k++) begin
      tick();
      bus.WrEn = 1; bus.Rw = 5'(k); bus.busW = 32'(k);
    end
    tick();
    idle();
    exp_q.push_back(mk(1, 31, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL fill_drained got=%h exp=%h", got, e); end
    tick();
    bus.WrEn = 1; bus.Rw = 1; bus.busW = 100;
    tick();
    idle();
    exp_q.push_back(mk(100, 31, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL no_underflow got=%h exp=%h", got, e); end
  endtask
  task automatic test_mid_reset();
    tick();
    bus.IssEn = 1; bus.Rd_iss = 3;
    tick();
    bus.Rd_iss = 7;
    tick();
    idle();
    bus.Ra = {5'd7, 5'd3};
    exp_q.push_back(mk(3, 7, 2'b00, 0, 2));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL pre_reset got=%h exp=%h", got, e); end
    tick();
    bus.WrEn = 1; bus.Rw = 3; bus.busW = 32'h55; Rst = 1;
    tick();
    Rst = 0; idle();
    exp_q.push_back(mk(0, 0, 2'b11, 1, 0));
    #1; got = cur(); e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL mid_reset got=%h exp=%h", got, e); end
  endtask
  initial begin
    test_reset();
    test_write_bypass();
    test_raw();
    test_waw();
    test_fill();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_sb.md
# rf_sb

Parametrised register file for the pipelined datapath with NRD combinational read ports and one synchronous write port. Register 0 is hardwired to zero, and a same-cycle write-to-read bypass is built in. It also carries a per-register pending-write scoreboard, so issue logic can detect RAW and WAW hazards without a separate hazard table. It sits between decode (read/issue) and write-back.

## Interface
- DW, 32, data width
- AW, 5, register address width; NREG = 2**AW registers
- NRD, 2, number of read ports
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- WrEn  in  1  write-back enable
- Rw  in  AW  write-back register address
- busW  in  DW  write-back data
- Ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- busA  out  NRD*DW  read data, port i at [i*DW +: DW]
- Rdy  out  NRD  port i operand valid (not pending, or bypassed this cycle)
- IssEn  in  1  instruction issuing with destination Rd_iss
- Rd_iss  in  AW  destination of issuing instruction
- IssOk  out  1  Rd_iss has no outstanding write (WAW-safe)
- PendCnt  out  AW+1  number of registers currently pending

## Operation
- **Reset.** When Rst=1 at an edge:
  - All R[k] are cleared to 0.
  - All pend[k] are cleared to 0.
  - PendCnt is set to 0.
  - Rst has priority over WrEn and IssEn in the same cycle.
  - After reset: busA=0 on every port, Rdy all 1, IssOk=1.
- **Write.** If WrEn=1 and Rw!=0, R[Rw] takes busW at the edge. A write to Rw=0 is ignored.
- **Read.** Per port i, with a = Ra[i], combinational priority:
  - a==0: busA=0.
  - else WrEn=1 and Rw==a: busA=busW (bypass).
  - else: busA=R[a].
- **Ready.** Rdy[i] is 1 when any of the following holds:
  - a==0
  - pend[a]==0
  - WrEn=1 and Rw==a (bypass)
- **Scoreboard set/clear.**
  - IssEn=1 with Rd_iss!=0 sets pend[Rd_iss].
  - WrEn=1 with Rw!=0 clears pend[Rw].
  - Same register set and cleared in one cycle: set wins, since the new producer supersedes the retiring one.
- **IssOk.** IssOk = (Rd_iss==0) or pend[Rd_iss]==0 or (WrEn=1 and Rw==Rd_iss).
  - Issue logic must not assert IssEn while IssOk=0.
  - If it does, the block still sets/keeps pend; it is a single bit, not counted.
- **PendCnt.** Registered counter, equal to the popcount of pend at all times. Next value = PendCnt + s − c, where:
  - s = 1 if a set hits a register that was not pending;
  - c = 1 if a clear hits a pending register that is not being set in the same cycle;
  - set and clear on the same register: net 0.
- **Width rules.** No arithmetic on data. PendCnt never exceeds NREG−1, because register 0 is never pending.

## Timing
- Read path is combinational from Ra, Rw, WrEn, busW to busA and Rdy: zero latency.
- Write data is visible through R[] one cycle after the WrEn edge, and through the bypass in the same cycle.
- pend, PendCnt and IssOk reflect an issue one cycle after the IssEn edge.
- A write-back clears pend at the edge; Rdy already shows 1 in the write-back cycle via the bypass.
- Reset mid-operation discards in-flight writes and pending state in that same edge. The next cycle shows the reset state.

## Structure
- Shared package rf_pkg holds:
  - default DW, AW, NRD;
  - NREG = 2**AW;
  - localparam ZERO_REG = 0.
- Sub-module rf_scoreboard holds:
  - the pend vector, PendCnt, and IssOk;
  - inputs Clk, Rst, IssEn, Rd_iss, WrEn, Rw, and the NRD read addresses;
  - outputs per-port pending bits.
- The top level holds the storage array, the bypass muxes and the Rdy combine.

## Test plan
- **Reset then read.** Rst 1 cycle, Ra={10,11} -> busA={0,0}, Rdy=2'b11, PendCnt=0, IssOk=1.
- **Write, bypass, register 0.**
  - WrEn=1, Rw=10, busW=32'h7, Ra[0]=10 in the same cycle -> busA[0]=7 that cycle; next cycle with WrEn=0 still 7.
  - Rw=0, busW=32'hFFFF_FFFF -> busA for Ra=0 stays 0.
- **RAW hazard.**
  - IssEn, Rd_iss=11 -> next cycle Ra[1]=11 gives Rdy[1]=0, PendCnt=1.
  - WrEn, Rw=11, busW=15 -> same cycle Rdy[1]=1, busA[1]=15; next cycle PendCnt=0.
- **WAW and simultaneous set/clear.**
  - Pend r5; Rd_iss=5 -> IssOk=0.
  - IssEn Rd_iss=5 with WrEn Rw=5 in the same cycle -> pend[5] stays 1, PendCnt unchanged.
- **Counter fill.** Issue r1..r31 on consecutive cycles -> PendCnt reaches 31. Then retire all -> PendCnt returns to 0, with no underflow on an extra write to an already non-pending register.
- **Mid-operation reset.** With r3 and r7 pending and WrEn Rw=3 asserted, assert Rst -> next cycle R[3]=0, PendCnt=0, Rdy all 1.
